// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, instruction
// classes, data-processing commands, ALU controls and datapath mux selects.
package arm_ctrl_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_FPEXEC = 4'd10,
        S_FPWB   = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_FP  = 2'b11
    } op_e;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;
    localparam logic [3:0] ALU_MOV = 4'b0111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mc_decode_aludec.sv
// ALU decoder: maps the data-processing command to an ALU operation and
// derives flag write enables; idle (ADD, no flag writes) outside ALU states.
module mc_decode_aludec
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cmd_i,
    input  logic       s_i,
    input  logic       alu_op_i,
    input  logic       fp_i,
    output logic [3:0] alu_control_o,
    output logic [1:0] flag_w_o
);

    logic add_sub;

    always_comb begin
        alu_control_o = ALU_ADD;
        flag_w_o      = 2'b00;
        add_sub       = 1'b0;
        if (alu_op_i) begin
            case (cmd_i)
                CMD_ADD: begin
                    alu_control_o = ALU_ADD;
                    add_sub       = 1'b1;
                end
                CMD_SUB: begin
                    alu_control_o = ALU_SUB;
                    add_sub       = 1'b1;
                end
                CMD_AND: alu_control_o = ALU_AND;
                CMD_ORR: alu_control_o = ALU_ORR;
                CMD_EOR: alu_control_o = ALU_EOR;
                CMD_MOV: alu_control_o = ALU_MOV;
                default: alu_control_o = ALU_ADD;
            endcase
            // C/V only meaningful for arithmetic results
            if (!fp_i) begin
                flag_w_o = {s_i, s_i & add_sub};
            end
        end
    end

endmodule

// File: rtl/mc_decode.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute/writeback
// with a fixed- or handshake-latency FP execute path.
module mc_decode
    import arm_ctrl_pkg::*;
#(
    parameter int unsigned FP_LAT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       FPDone,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] ALUControl,
    output logic       FPStart,
    output logic       FPSel
);

    localparam int unsigned CNT_W    = (FP_LAT == 0) ? 1 : $clog2(FP_LAT + 1);
    localparam int unsigned CNT_LOAD = (FP_LAT == 0) ? 0 : FP_LAT - 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fp_start_q, fp_start_d;
    logic             alu_op, branch, fp_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            cnt_q      <= '0;
            fp_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fp_start_q <= fp_start_d;
        end
    end

    // Next state and FP latency counter
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fp_start_d = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: begin
                        state_d    = S_FPEXEC;
                        cnt_d      = CNT_W'(CNT_LOAD);
                        fp_start_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            S_FPEXEC: begin
                if (FP_LAT == 0) begin
                    if (FPDone) state_d = S_FPWB;
                end else if (cnt_q == '0) begin
                    state_d = S_FPWB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default:  state_d = S_FETCH;
        endcase
    end

    // Datapath controls decoded from the current state
    always_comb begin
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        FPSel     = 1'b0;
        alu_op    = 1'b0;
        branch    = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_MEMADR: ALUSrcB = SRCB_IMM;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_MEM;
                RegW      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECR: alu_op = 1'b1;
            S_EXECI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
            end
            S_ALUWB: RegW = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                branch    = 1'b1;
            end
            S_FPWB: begin
                RegW  = 1'b1;
                FPSel = 1'b1;
            end
            default: ;
        endcase
    end

    assign fp_state = (state_q == S_FPEXEC) || (state_q == S_FPWB);
    assign FPStart  = (state_q == S_FPEXEC) && fp_start_q;
    assign PCS      = ((Rd == 4'd15) && RegW) || branch;
    assign ImmSrc   = Op;
    assign RegSrc   = {Op == OP_MEM, Op == OP_BR};

    mc_decode_aludec u_aludec (
        .cmd_i         (Funct[4:1]),
        .s_i           (Funct[0]),
        .alu_op_i      (alu_op),
        .fp_i          (fp_state),
        .alu_control_o (ALUControl),
        .flag_w_o      (FlagW)
    );

endmodule

// File: tb/tb_mc_decode.sv
// Directed bench for mc_decode: per-cycle control vectors for each instruction
// class, fixed and handshaked FP latency, and asynchronous reset mid-FP.
module tb_mc_decode;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       fp_done;

    logic [1:0] a_flagw, a_resultsrc, a_alusrcb, a_immsrc, a_regsrc;
    logic       a_pcs, a_nextpc, a_regw, a_memw, a_irwrite, a_adrsrc, a_alusrca, a_fpstart, a_fpsel;
    logic [3:0] a_aluctl;
    logic [1:0] b_flagw, b_resultsrc, b_alusrcb, b_immsrc, b_regsrc;
    logic       b_pcs, b_nextpc, b_regw, b_memw, b_irwrite, b_adrsrc, b_alusrca, b_fpstart, b_fpsel;
    logic [3:0] b_aluctl;

    logic [18:0] obs_a, obs_b;
    logic [18:0] st_f, st_d, st_z;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_decode #(.FP_LAT(3)) u_dut_a (
        .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Rd(rd), .FPDone(fp_done),
        .FlagW(a_flagw), .PCS(a_pcs), .NextPC(a_nextpc), .RegW(a_regw), .MemW(a_memw),
        .IRWrite(a_irwrite), .AdrSrc(a_adrsrc), .ResultSrc(a_resultsrc), .ALUSrcA(a_alusrca),
        .ALUSrcB(a_alusrcb), .ImmSrc(a_immsrc), .RegSrc(a_regsrc), .ALUControl(a_aluctl),
        .FPStart(a_fpstart), .FPSel(a_fpsel)
    );

    mc_decode #(.FP_LAT(0)) u_dut_b (
        .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Rd(rd), .FPDone(fp_done),
        .FlagW(b_flagw), .PCS(b_pcs), .NextPC(b_nextpc), .RegW(b_regw), .MemW(b_memw),
        .IRWrite(b_irwrite), .AdrSrc(b_adrsrc), .ResultSrc(b_resultsrc), .ALUSrcA(b_alusrca),
        .ALUSrcB(b_alusrcb), .ImmSrc(b_immsrc), .RegSrc(b_regsrc), .ALUControl(b_aluctl),
        .FPStart(b_fpstart), .FPSel(b_fpsel)
    );

    assign obs_a = {a_flagw, a_pcs, a_nextpc, a_regw, a_memw, a_irwrite, a_adrsrc, a_resultsrc,
                    a_alusrca, a_alusrcb, a_aluctl, a_fpstart, a_fpsel};
    assign obs_b = {b_flagw, b_pcs, b_nextpc, b_regw, b_memw, b_irwrite, b_adrsrc, b_resultsrc,
                    b_alusrca, b_alusrcb, b_aluctl, b_fpstart, b_fpsel};

    // Packs one expected control vector in the same field order as obs_a/obs_b
    function automatic logic [18:0] pk(input logic [1:0] fw, input logic pcs, input logic npc,
                                       input logic regw, input logic memw, input logic irw,
                                       input logic adr, input logic [1:0] res, input logic srca,
                                       input logic [1:0] srcb, input logic [3:0] ctl,
                                       input logic fps, input logic fpsel);
        return {fw, pcs, npc, regw, memw, irw, adr, res, srca, srcb, ctl, fps, fpsel};
    endfunction

    task automatic start_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
        op    = o;
        funct = f;
        rd    = r;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        op = 2'b00; funct = 6'd0; rd = 4'd0; fp_done = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_a !== st_f) begin failures++; $display("FAIL reset_held_a got=%h exp=%h", obs_a, st_f); end
        checks++;
        if (obs_b !== st_f) begin failures++; $display("FAIL reset_held_b got=%h exp=%h", obs_b, st_f); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obs_a !== st_f) begin failures++; $display("FAIL reset_cyc0 got=%h exp=%h", obs_a, st_f); end
        @(negedge clk);
        checks++;
        if (obs_a !== st_d) begin failures++; $display("FAIL reset_cyc1_decode got=%h exp=%h", obs_a, st_d); end
    endtask

    task automatic test_adds_imm();
        logic [18:0] ev [$];
        ev = '{st_f, st_d,
               pk(2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 4'b0000, 0, 0),
               pk(2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 0, 0),
               st_f};
        start_instr(2'b00, 6'b101001, 4'd1);
        for (int k = 0; k < ev.size(); k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs_a !== ev[k]) begin failures++; $display("FAIL adds_imm cyc=%0d got=%h exp=%h", k, obs_a, ev[k]); end
        end
    endtask

    task automatic test_load_pc();
        logic [18:0] ev [$];
        ev = '{st_f, st_d,
               pk(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 4'b0000, 0, 0),
               pk(2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 4'b0000, 0, 0),
               pk(2'b00, 1, 0, 1, 0, 0, 0, 2'b01, 0, 2'b00, 4'b0000, 0, 0),
               st_f};
        start_instr(2'b01, 6'b011001, 4'd15);
        for (int k = 0; k < ev.size(); k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs_a !== ev[k]) begin failures++; $display("FAIL ldr_pc cyc=%0d got=%h exp=%h", k, obs_a, ev[k]); end
        end
        checks++;
        if ({a_immsrc, a_regsrc} !== 4'b0110) begin
            failures++; $display("FAIL ldr_imm_reg_src got=%b exp=0110", {a_immsrc, a_regsrc});
        end
    endtask

    task automatic test_store();
        logic [18:0] ev [$];
        ev = '{st_f, st_d,
               pk(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 4'b0000, 0, 0),
               pk(2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 2'b00, 4'b0000, 0, 0),
               st_f};
        start_instr(2'b01, 6'b011000, 4'd3);
        for (int k = 0; k < ev.size(); k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs_a !== ev[k]) begin failures++; $display("FAIL str cyc=%0d got=%h exp=%h", k, obs_a, ev[k]); end
        end
    endtask

    task automatic test_branch();
        logic [18:0] ev [$];
        ev = '{st_f, st_d,
               pk(2'b00, 1, 0, 0, 0, 0, 0, 2'b10, 0, 2'b01, 4'b0000, 0, 0),
               st_f};
        start_instr(2'b10, 6'b100000, 4'd0);
        for (int k = 0; k < ev.size(); k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs_a !== ev[k]) begin failures++; $display("FAIL branch cyc=%0d got=%h exp=%h", k, obs_a, ev[k]); end
        end
        checks++;
        if ({a_immsrc, a_regsrc} !== 4'b1001) begin
            failures++; $display("FAIL b_imm_reg_src got=%b exp=1001", {a_immsrc, a_regsrc});
        end
    endtask

    task automatic test_alu_decode();
        logic [5:0] fn  [7] = '{6'b011001, 6'b000101, 6'b100100, 6'b000011, 6'b111010, 6'b000001, 6'b010101};
        logic [3:0] ctl [7] = '{4'b0011,   4'b0001,   4'b0001,   4'b0100,   4'b0111,   4'b0010,   4'b0000};
        logic [1:0] fw  [7] = '{2'b10,     2'b11,     2'b00,     2'b10,     2'b00,     2'b10,     2'b10};
        logic [1:0] sb  [7] = '{2'b00,     2'b00,     2'b01,     2'b00,     2'b01,     2'b00,     2'b00};
        logic [18:0] e;
        for (int i = 0; i < 7; i++) begin
            start_instr(2'b00, fn[i], 4'd2);
            @(negedge clk);
            @(negedge clk);
            e = pk(fw[i], 0, 0, 0, 0, 0, 0, 2'b00, 0, sb[i], ctl[i], 0, 0);
            checks++;
            if (obs_a !== e) begin failures++; $display("FAIL alu_exec funct=%b got=%h exp=%h", fn[i], obs_a, e); end
        end
        // ADD to R15: ALU writeback must redirect the PC
        start_instr(2'b00, 6'b001000, 4'd15);
        repeat (3) @(negedge clk);
        e = pk(2'b00, 1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 0, 0);
        checks++;
        if (obs_a !== e) begin failures++; $display("FAIL alu_wb_pcs got=%h exp=%h", obs_a, e); end
    endtask

    task automatic test_fp_fixed();
        logic [18:0] ev [$];
        ev = '{st_f, st_d,
               pk(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 1, 0),
               st_z, st_z,
               pk(2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 0, 1),
               st_f};
        fp_done = 1'b0;
        start_instr(2'b11, 6'b000001, 4'd4);
        for (int k = 0; k < ev.size(); k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs_a !== ev[k]) begin failures++; $display("FAIL fp_fixed cyc=%0d got=%h exp=%h", k, obs_a, ev[k]); end
        end
    endtask

    task automatic test_fp_done_entry();
        logic [18:0] ea [$];
        logic [18:0] eb [$];
        ea = '{st_f, st_d,
               pk(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 1, 0),
               st_z, st_z,
               pk(2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 0, 1),
               st_f};
        eb = '{st_f, st_d,
               pk(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 1, 0),
               pk(2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 0, 1),
               st_f};
        fp_done = 1'b1;
        start_instr(2'b11, 6'b000000, 4'd5);
        for (int k = 0; k < ea.size(); k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs_a !== ea[k]) begin failures++; $display("FAIL fp_done_ignored cyc=%0d got=%h exp=%h", k, obs_a, ea[k]); end
            if (k < eb.size()) begin
                checks++;
                if (obs_b !== eb[k]) begin failures++; $display("FAIL fp_var_entry_done cyc=%0d got=%h exp=%h", k, obs_b, eb[k]); end
            end
        end
        fp_done = 1'b0;
    endtask

    task automatic test_fp_variable();
        logic [18:0] ev [$];
        ev = '{st_f, st_d,
               pk(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 1, 0),
               st_z, st_z, st_z, st_z,
               pk(2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 0, 1),
               st_f};
        fp_done = 1'b0;
        start_instr(2'b11, 6'b000000, 4'd6);
        for (int k = 0; k < ev.size(); k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs_b !== ev[k]) begin failures++; $display("FAIL fp_variable cyc=%0d got=%h exp=%h", k, obs_b, ev[k]); end
            if (k == 6) fp_done = 1'b1;
            if (k == 7) fp_done = 1'b0;
        end
    endtask

    task automatic test_reset_mid_fp();
        logic [18:0] ev [$];
        ev = '{st_f, st_d,
               pk(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 1, 0),
               st_z, st_z,
               pk(2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 4'b0000, 0, 1),
               st_f};
        fp_done = 1'b0;
        start_instr(2'b11, 6'b000000, 4'd7);
        repeat (3) @(negedge clk);
        checks++;
        if (obs_a !== st_z) begin failures++; $display("FAIL fp_second_cycle got=%h exp=%h", obs_a, st_z); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (obs_a !== st_f) begin failures++; $display("FAIL async_reset_fp got=%h exp=%h", obs_a, st_f); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int k = 0; k < ev.size(); k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs_a !== ev[k]) begin failures++; $display("FAIL fp_after_reset cyc=%0d got=%h exp=%h", k, obs_a, ev[k]); end
        end
    endtask

    initial begin
        st_f = pk(2'b00, 0, 1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 4'b0000, 0, 0);
        st_d = pk(2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 4'b0000, 0, 0);
        st_z = '0;
        test_reset();
        test_adds_imm();
        test_load_pc();
        test_store();
        test_branch();
        test_alu_decode();
        test_fp_fixed();
        test_fp_done_entry();
        test_fp_variable();
        test_reset_mid_fp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
